// File: rtl/trap_arb_mh_pkg.sv
// Shared encodings for the multi-hart M-mode trap arbiter.
// Cause codes, interrupt bit positions, mtvec modes, FSM states.
package trap_arb_mh_pkg;

  localparam int MCAUSE_MEI = 11;
  localparam int MCAUSE_MSI = 3;
  localparam int MCAUSE_MTI = 7;

  // Bit positions inside each 3-bit per-hart {E,T,S} group
  localparam int INT_BIT_E = 2;
  localparam int INT_BIT_T = 1;
  localparam int INT_BIT_S = 0;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GUARD = 2'd2
  } trap_state_e;

  // Highest-priority active interrupt: MEI > MSI > MTI
  function automatic logic [3:0] int_code(input logic [2:0] act);
    logic [3:0] c;
    c = 4'(MCAUSE_MTI);
    if (act[INT_BIT_S]) c = 4'(MCAUSE_MSI);
    if (act[INT_BIT_E]) c = 4'(MCAUSE_MEI);
    return c;
  endfunction

endpackage

// File: rtl/trap_arb_mh_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after last grant.
// Ports: clk, rst, req, advance/adv_idx (pointer update), gnt, gnt_idx.
module trap_arb_mh_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] adv_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[IW'(k)]) begin
        found          = 1'b1;
        gnt[IW'(k)]    = 1'b1;
        gnt_idx        = IW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(adv_idx) == N - 1) ? '0 : adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/trap_arb_mh.sv
// Multi-hart M-mode trap controller: per-hart exception slot, gated
// MEI/MSI/MTI, round-robin across harts, registered valid/ready offer.
// Ports: ex_* capture, per-hart CSR views, trap_* offer to pipeline.
module trap_arb_mh
  import trap_arb_mh_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_HARTS = 4,
  parameter int HART_ID_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  parameter logic [NUM_HARTS-1:0] INT_HART_MASK = NUM_HARTS'(1),
  parameter int ECAUSE_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [HART_ID_W-1:0]   ex_hart_id,
  input  logic [ECAUSE_W-1:0]    ex_cause,
  input  logic [XLEN-1:0]        ex_pc,
  input  logic [XLEN-1:0]        ex_tval,
  input  logic [NUM_HARTS*XLEN-1:0] hart_pc,
  input  logic [NUM_HARTS*XLEN-1:0] mtvec,
  input  logic [NUM_HARTS-1:0]   mstatus_mie,
  input  logic [NUM_HARTS*3-1:0] mie_bits,
  input  logic [NUM_HARTS*3-1:0] mip_bits,
  output logic                   trap_valid,
  input  logic                   trap_ready,
  output logic [HART_ID_W-1:0]   trap_hart_id,
  output logic [XLEN-1:0]        trap_vector,
  output logic [XLEN-1:0]        trap_mepc,
  output logic [XLEN-1:0]        trap_mcause,
  output logic [XLEN-1:0]        trap_mtval,
  output logic                   trap_is_int
);

  logic [NUM_HARTS-1:0] ex_pend, int_req, cand, gnt;
  logic [2:0]           act [NUM_HARTS];
  logic [ECAUSE_W-1:0]  slot_cause [NUM_HARTS];
  logic [XLEN-1:0]      slot_pc [NUM_HARTS];
  logic [XLEN-1:0]      slot_tval [NUM_HARTS];
  logic [HART_ID_W-1:0] sel;
  logic                 cap, hs;
  trap_state_e          state;

  logic                 s_int;
  logic [3:0]           s_code;
  logic [XLEN-1:0]      s_tvec, s_base, s_vec;
  logic [XLEN-1:0]      s_mcause, s_mepc, s_mtval;

  assign ex_ready = !ex_pend[ex_hart_id];
  assign cap      = ex_valid && ex_ready;
  assign hs       = trap_valid && trap_ready;

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      act[h]     = mie_bits[3*h +: 3] & mip_bits[3*h +: 3];
      int_req[h] = INT_HART_MASK[h] & mstatus_mie[h] & (|act[h]);
    end
  end

  // A pending exception always makes the hart a candidate and wins
  assign cand = ex_pend | int_req;

  trap_arb_mh_rr_arbiter #(
    .N  (NUM_HARTS),
    .IW (HART_ID_W)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (cand),
    .advance (hs),
    .adv_idx (trap_hart_id),
    .gnt     (gnt),
    .gnt_idx (sel)
  );

  always_comb begin
    s_int    = !ex_pend[sel];
    s_code   = int_code(act[sel]);
    s_tvec   = mtvec[int'(sel)*XLEN +: XLEN];
    s_base   = {s_tvec[XLEN-1:2], 2'b00};
    s_vec    = s_base;
    s_mcause = XLEN'(slot_cause[sel]);
    s_mepc   = slot_pc[sel];
    s_mtval  = slot_tval[sel];
    if (s_int) begin
      s_mcause = {1'b1, {(XLEN-5){1'b0}}, s_code};
      s_mepc   = hart_pc[int'(sel)*XLEN +: XLEN];
      s_mtval  = '0;
      if (s_tvec[1:0] == MTVEC_MODE_VECTORED)
        s_vec = s_base + XLEN'({s_code, 2'b00});
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      slot_cause[ex_hart_id] <= ex_cause;
      slot_pc[ex_hart_id]    <= ex_pc;
      slot_tval[ex_hart_id]  <= ex_tval;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ex_pend      <= '0;
      trap_valid   <= 1'b0;
      trap_hart_id <= '0;
      trap_vector  <= '0;
      trap_mepc    <= '0;
      trap_mcause  <= '0;
      trap_mtval   <= '0;
      trap_is_int  <= 1'b0;
    end else begin
      if (cap) ex_pend[ex_hart_id] <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (|gnt) begin
            trap_valid   <= 1'b1;
            trap_hart_id <= sel;
            trap_vector  <= s_vec;
            trap_mepc    <= s_mepc;
            trap_mcause  <= s_mcause;
            trap_mtval   <= s_mtval;
            trap_is_int  <= s_int;
            state        <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (trap_ready) begin
            trap_valid <= 1'b0;
            if (!trap_is_int) ex_pend[trap_hart_id] <= 1'b0;
            state <= ST_GUARD;
          end
        end
        // Lets the pipeline's CSR write land before re-arbitrating
        ST_GUARD: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_arb_mh.sv
// Randomized + directed bench for trap_arb_mh with a transaction model.
// Model predicts each offer from the trap rules at the decision edge.
module tb_trap_arb_mh;

  localparam int XLEN = 32;
  localparam int NH   = 4;
  localparam int HW   = 2;
  localparam int EW   = 5;
  localparam logic [NH-1:0] MASK = 4'b0001;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid, ex_ready;
  logic [HW-1:0]   ex_hart_id;
  logic [EW-1:0]   ex_cause;
  logic [31:0]     ex_pc, ex_tval;
  logic [NH*32-1:0] hart_pc, mtvec;
  logic [NH-1:0]   mstatus_mie;
  logic [NH*3-1:0] mie_bits, mip_bits;
  logic            trap_valid, trap_ready, trap_is_int;
  logic [HW-1:0]   trap_hart_id;
  logic [31:0]     trap_vector, trap_mepc, trap_mcause, trap_mtval;

  always #5 clk = ~clk;

  trap_arb_mh #(
    .XLEN(XLEN), .NUM_HARTS(NH), .HART_ID_W(HW),
    .INT_HART_MASK(MASK), .ECAUSE_W(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_hart_id(ex_hart_id), .ex_cause(ex_cause),
    .ex_pc(ex_pc), .ex_tval(ex_tval),
    .hart_pc(hart_pc), .mtvec(mtvec),
    .mstatus_mie(mstatus_mie),
    .mie_bits(mie_bits), .mip_bits(mip_bits),
    .trap_valid(trap_valid), .trap_ready(trap_ready),
    .trap_hart_id(trap_hart_id), .trap_vector(trap_vector),
    .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
    .trap_mtval(trap_mtval), .trap_is_int(trap_is_int)
  );

  typedef struct {
    int          hart;
    logic [31:0] vec, mepc, mcause, mtval;
    logic        is_int;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          m_pend [NH];
  logic [4:0]  m_cause [NH];
  logic [31:0] m_pc [NH];
  logic [31:0] m_tval [NH];
  int          m_ptr;
  int          m_phase;   // 0 free, 1 offering, 2 settling
  exp_t        m_exp;
  int          hs_cyc[$];
  int          hs_hart[$];
  logic [31:0] codes [3] = '{32'h8000_000B, 32'h8000_0003, 32'h8000_0007};
  int          ackbit [3] = '{2, 0, 1};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit hart_int(input int h);
    logic [2:0] a;
    a = mie_bits[3*h +: 3] & mip_bits[3*h +: 3];
    return MASK[h] && mstatus_mie[h] && (a != 3'b000);
  endfunction

  function automatic bit pick(output exp_t e);
    int h, code;
    logic [31:0] tv, base;
    logic [2:0] a;
    e = '{default: 0};
    for (int k = 0; k < NH; k++) begin
      h = (m_ptr + k) % NH;
      if (m_pend[h] || hart_int(h)) begin
        tv = mtvec[32*h +: 32];
        base = {tv[31:2], 2'b00};
        e.hart = h;
        e.is_int = !m_pend[h];
        if (m_pend[h]) begin
          e.mcause = {27'd0, m_cause[h]};
          e.mepc = m_pc[h];
          e.mtval = m_tval[h];
          e.vec = base;
        end else begin
          a = mie_bits[3*h +: 3] & mip_bits[3*h +: 3];
          code = a[2] ? 11 : (a[0] ? 3 : 7);
          e.mcause = 32'h8000_0000 + 32'(code);
          e.mepc = hart_pc[32*h +: 32];
          e.mtval = 32'd0;
          e.vec = (tv[1:0] == 2'd1) ? base + 32'(4 * code) : base;
        end
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic tick();
    bit cap, hs, dec;
    exp_t nx;
    int id;
    #1;
    id = int'(ex_hart_id);
    if (!rst) chk("ex_ready", ex_ready, !m_pend[id]);
    cap = ex_valid && !m_pend[id];
    hs  = (m_phase == 1) && trap_ready;
    dec = (m_phase == 0) && pick(nx);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr = 0;
      m_phase = 0;
    end else begin
      if (cap) begin
        m_pend[id] = 1'b1;
        m_cause[id] = ex_cause;
        m_pc[id] = ex_pc;
        m_tval[id] = ex_tval;
      end
      if (hs) begin
        if (!m_exp.is_int) m_pend[m_exp.hart] = 1'b0;
        m_ptr = (m_exp.hart + 1) % NH;
        m_phase = 2;
        hs_cyc.push_back(cyc);
        hs_hart.push_back(m_exp.hart);
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (dec) begin
        m_exp = nx;
        m_phase = 1;
      end
    end
    chk("trap_valid", trap_valid, m_phase == 1);
    if (m_phase == 1) begin
      chk("hart", trap_hart_id, m_exp.hart);
      chk("vector", trap_vector, m_exp.vec);
      chk("mepc", trap_mepc, m_exp.mepc);
      chk("mcause", trap_mcause, m_exp.mcause);
      chk("mtval", trap_mtval, m_exp.mtval);
      chk("is_int", trap_is_int, m_exp.is_int);
    end
  endtask

  task automatic inject(input int h, input logic [4:0] c,
                        input logic [31:0] pc, input logic [31:0] tv);
    ex_hart_id = HW'(h);
    ex_cause = c;
    ex_pc = pc;
    ex_tval = tv;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic wait_offer(input string tag);
    int n;
    n = 0;
    while (!trap_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, trap_valid, 1);
  endtask

  task automatic accept();
    trap_ready = 1'b1;
    tick();
    trap_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_hart_id = '0; ex_cause = '0;
    ex_pc = '0; ex_tval = '0;
    hart_pc = '0; mtvec = '0; mstatus_mie = '0;
    mie_bits = '0; mip_bits = '0; trap_ready = 1'b0;
    m_ptr = 0; m_phase = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_hart", trap_hart_id, 0);
    chk("rst_vec", trap_vector, 0);
    chk("rst_mepc", trap_mepc, 0);
    chk("rst_mcause", trap_mcause, 0);
    chk("rst_mtval", trap_mtval, 0);
    chk("rst_isint", trap_is_int, 0);

    // Exception on hart 2, direct base from a vectored mtvec
    mtvec[64 +: 32] = 32'h8000_0001;
    inject(2, 5'd2, 32'h100, 32'hDEAD);
    tick();
    chk("t1_hart", trap_hart_id, 2);
    chk("t1_vec", trap_vector, 32'h8000_0000);
    chk("t1_mcause", trap_mcause, 32'd2);
    chk("t1_mepc", trap_mepc, 32'h100);
    chk("t1_mtval", trap_mtval, 32'hDEAD);
    accept();
    tick();
    ex_hart_id = 2'd2;
    #1 chk("t1_clear", ex_ready, 1);

    // Vectored MEI on hart 0, held across 5 stalled cycles
    mtvec[0 +: 32] = 32'h4001;
    hart_pc[0 +: 32] = 32'h1234;
    mie_bits[2:0] = 3'b100;
    mip_bits[2:0] = 3'b100;
    mstatus_mie[0] = 1'b1;
    tick();
    chk("t2_vec", trap_vector, 32'h402C);
    chk("t2_mcause", trap_mcause, 32'h8000_000B);
    chk("t2_mepc", trap_mepc, 32'h1234);
    mip_bits[2:0] = 3'b000;
    mstatus_mie[0] = 1'b0;
    hart_pc[0 +: 32] = 32'h9999;
    repeat (5) begin
      tick();
      chk("t2_hold_vec", trap_vector, 32'h402C);
      chk("t2_hold_mepc", trap_mepc, 32'h1234);
    end
    accept();
    tick();

    // Hart 1 is masked from interrupts
    mstatus_mie = '1;
    mie_bits[5:3] = 3'b001;
    mip_bits[5:3] = 3'b001;
    repeat (8) begin
      tick();
      chk("t3_noint", trap_valid, 0);
    end
    mstatus_mie = '0;
    mie_bits = '0;
    mip_bits = '0;

    // Hart 0: exception beats MEI/MSI/MTI, then MEI > MSI > MTI
    mie_bits[2:0] = 3'b111;
    mip_bits[2:0] = 3'b111;
    inject(1, 5'd1, 32'h200, 32'h0);
    ex_hart_id = 2'd0; ex_cause = 5'd5;
    ex_pc = 32'h300; ex_tval = 32'hBAD;
    ex_valid = 1'b1;
    mstatus_mie[0] = 1'b1;
    tick();
    ex_valid = 1'b0;
    chk("t4_first", trap_hart_id, 1);
    accept();
    wait_offer("t4_ex");
    chk("t4_ex_hart", trap_hart_id, 0);
    chk("t4_ex_int", trap_is_int, 0);
    chk("t4_ex_cause", trap_mcause, 32'd5);
    accept();
    for (int k = 0; k < 3; k++) begin
      wait_offer("t4_int");
      chk("t4_order", trap_mcause, codes[k]);
      accept();
      mip_bits[ackbit[k]] = 1'b0;
    end
    tick();
    mstatus_mie = '0;
    mie_bits = '0;

    // Back-to-back exceptions on 0,1,3 with ready held high
    hs_cyc.delete();
    hs_hart.delete();
    trap_ready = 1'b1;
    inject(0, 5'd4, 32'h400, 32'h1);
    inject(1, 5'd6, 32'h500, 32'h2);
    ex_hart_id = 2'd1; ex_valid = 1'b1;
    #1 chk("t5_busy", ex_ready, 0);
    tick();
    ex_valid = 1'b0;
    inject(3, 5'd7, 32'h600, 32'h3);
    repeat (10) tick();
    trap_ready = 1'b0;
    chk("t5_n", hs_hart.size(), 3);
    if (hs_hart.size() == 3) begin
      chk("t5_h0", hs_hart[0], 0);
      chk("t5_h1", hs_hart[1], 1);
      chk("t5_h2", hs_hart[2], 3);
      chk("t5_gap1", hs_cyc[1] - hs_cyc[0], 3);
      chk("t5_gap2", hs_cyc[2] - hs_cyc[1], 3);
    end

    // Reset during an offer, arbiter restarts at hart 0
    inject(1, 5'd2, 32'h700, 32'h0);
    wait_offer("t6_a");
    accept();
    tick();
    inject(2, 5'd3, 32'h800, 32'h5);
    wait_offer("t6_b");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", trap_valid, 0);
    chk("t6_mcause", trap_mcause, 0);
    ex_hart_id = 2'd2;
    #1 chk("t6_pend", ex_ready, 1);
    inject(3, 5'd1, 32'h900, 32'h0);
    mie_bits[2:0] = 3'b100;
    mip_bits[2:0] = 3'b100;
    mstatus_mie[0] = 1'b1;
    tick();
    chk("t6_hart", trap_hart_id, 0);
    chk("t6_int", trap_is_int, 1);
    accept();
    mstatus_mie = '0;
    mip_bits = '0;
    wait_offer("t6_c");
    chk("t6_next", trap_hart_id, 3);
    accept();
    tick();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      ex_valid = ($urandom_range(0, 3) == 0);
      ex_hart_id = HW'($urandom_range(0, NH - 1));
      ex_cause = EW'($urandom);
      ex_pc = $urandom;
      ex_tval = $urandom;
      trap_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) begin
        mstatus_mie = NH'($urandom);
        mie_bits = 12'($urandom);
        mip_bits = 12'($urandom);
        for (int h = 0; h < NH; h++) begin
          hart_pc[32*h +: 32] = $urandom;
          mtvec[32*h +: 32] = $urandom;
        end
      end
      tick();
    end
    rst = 1'b0;
    ex_valid = 1'b0;
    mstatus_mie = '0;
    trap_ready = 1'b1;
    repeat (30) tick();
    chk("drain_idle", trap_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_arb_mh.md
Name: trap_arb_mh

Overview:
- Multi-hart, multi-source machine-mode trap controller for the interleaved-hart core.
- Each hart has one pending-exception slot. Per hart, the block gates MEI/MSI/MTI through that hart's mstatus.MIE and mie/mip bits.
- It arbitrates round-robin across harts and offers one registered trap at a time to the pipeline over a valid/ready handshake.
- Supports direct and vectored mtvec per hart; any subset of harts can receive interrupts.

Parameters:
- XLEN, 32, data/address width.
- NUM_HARTS, 4, number of harts served.
- HART_ID_W, $clog2(NUM_HARTS) (min 1), hart index width.
- INT_HART_MASK, 1, bit h=1 lets hart h take interrupts. Exceptions are always taken.
- ECAUSE_W, 5, exception cause code width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  pipeline reports a synchronous exception
- ex_ready  out  1  = !ex_pend[ex_hart_id], combinational
- ex_hart_id  in  HART_ID_W  faulting hart
- ex_cause  in  ECAUSE_W  exception code
- ex_pc  in  XLEN  faulting PC
- ex_tval  in  XLEN  mtval value
- hart_pc  in  NUM_HARTS*XLEN  per-hart next PC, used as mepc for interrupts
- mtvec  in  NUM_HARTS*XLEN  per-hart mtvec
- mstatus_mie  in  NUM_HARTS  per-hart mstatus.MIE
- mie_bits  in  NUM_HARTS*3  per hart {MEIE,MTIE,MSIE}
- mip_bits  in  NUM_HARTS*3  per hart {MEIP,MTIP,MSIP}
- trap_valid  out  1  trap offer
- trap_ready  in  1  pipeline accepts: flush and redirect the hart, write its CSRs
- trap_hart_id  out  HART_ID_W  target hart
- trap_vector  out  XLEN  redirect PC
- trap_mepc  out  XLEN  value for mepc
- trap_mcause  out  XLEN  value for mcause
- trap_mtval  out  XLEN  value for mtval
- trap_is_int  out  1  1 = interrupt, 0 = exception

Behaviour:
- Exception capture: on ex_valid && ex_ready, latch cause/pc/tval into slot[ex_hart_id] and set ex_pend.
  - Offered with ex_ready=0: ignored. The pipeline must hold the offer.
  - A slot is cleared only by the handshake that delivers it.
- Candidate for hart h (combinational):
  - ex_pend[h] is a candidate.
  - Otherwise, if INT_HART_MASK[h] && mstatus_mie[h], take the first of MEI > MSI > MTI with enable && pending.
  - Exception beats interrupt within a hart.
- Arbitration: rr_arbiter over the candidate vector. Search starts at the hart after the last granted one; pointer resets to hart 0 (search starts at hart 0).
- FSM IDLE / OFFER / GUARD:
  - IDLE: if any candidate, register the selected hart's fields and go to OFFER. trap_valid=1 the next cycle (1-cycle latency from candidate to offer).
  - OFFER: all trap_* outputs held stable until trap_ready. The offer is never withdrawn, even if mip/mie/MIE drop.
    - On handshake: clear that hart's ex_pend if trap_is_int=0, advance the rr pointer, go to GUARD.
  - GUARD: one idle cycle, trap_valid=0, so the CSR update (MIE<=0) is visible before re-arbitration. Then IDLE.
  - Back-to-back throughput: one trap per 3 cycles.
- mcause:
  - Interrupt: bit XLEN-1 set, code MEI=11, MSI=3, MTI=7.
  - Exception: zero-extended ex_cause.
- mtval: slot tval for exceptions, 0 for interrupts.
- mepc: slot pc for exceptions, hart_pc[h] sampled at the IDLE→OFFER edge for interrupts.
- trap_vector: base={mtvec[XLEN-1:2],2'b00}.
  - mode=mtvec[1:0]==1 and interrupt: base+4*code, wraps modulo 2^XLEN.
  - Otherwise, including modes 2 and 3: base.
- Simultaneous events:
  - A new exception for hart A in the same cycle as a handshake for hart A's exception: not possible (ex_ready=0 then); accepted from the next cycle.
  - A new exception for another hart during OFFER is captured normally.
- Reset: FSM to IDLE; trap_valid=0; all trap_* outputs 0; ex_pend all 0; rr pointer reset. Reset during OFFER drops the offer with no CSR side effects.

Decomposition:
- Shared defines:
  - MCAUSE_MEI/MSI/MTI codes.
  - Interrupt bit index, {E,T,S} bit positions within the 3-bit per-hart groups.
  - MTVEC_MODE_DIRECT/VECTORED encodings.
  - FSM state encodings.
- Sub-module rr_arbiter: N-wide request vector, one-hot grant, pointer update on an advance strobe.

Test Plan:
- Hart 2 ex_valid, cause=2, pc=0x100, tval=0xDEAD, mtvec[2]=0x8000_0001 → next cycle trap_valid, hart 2, vector 0x8000_0000, mcause 2, mepc 0x100, mtval 0xDEAD; after ready, ex_pend[2]=0.
- Hart 0 MEI pending with MIE=1, MEIE=1, vectored mtvec 0x4001 → vector 0x402C, mcause 0x8000_000B, mepc=hart_pc[0]; trap_ready held 0 for 5 cycles and mip dropped → outputs stable throughout.
- INT_HART_MASK=4'b0001, MSI pending on hart 1 only → trap_valid never asserts.
- Hart 0 has MEI+MSI+MTI pending plus a pending exception → exception offered first; then, once CSR MIE is restored, MEI before MSI before MTI.
- Exceptions pending on harts 0, 1, 3 with trap_ready=1 → grants 0, 1, 3 spaced 3 cycles apart; re-offer for hart 1 while its slot is full → ex_ready=0.
- Assert rst during OFFER → trap_valid=0 the next cycle, ex_pend=0, arbiter restarts from hart 0.
